line_mem_responder: RTL and testbench

Main-memory responder for the data cache's cache-line refill/writeback interface. It grants one line request at a time, holds the line address and write data, and waits a fixed, parameterised access latency. It then returns a full line (`rvalid_o`) for reads, or commits the line and pulses `write_done_o` for writes. It sits below the data cache and is the counterpart of the cache's `mem_req` / `mem_we` / `mem_gnt` / `mem_rvalid` interface, with line-wide storage and no byte strobes.

---
 rtl/line_mem_responder.sv | 135 +++++++++++++
 tb/tb_line_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : line_mem_responder
//  Purpose  : Line-wide main-memory responder for cache refill and writeback.
//             Serves one request at a time after a fixed access latency.
//  Revision : 1.0  initial release
// ============================================================================
module line_mem_responder #(
  parameter int unsigned MEM_SIZE   = 32'h0010_0000,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned RD_LATENCY = 5,
  parameter int unsigned WR_LATENCY = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rd_req_valid_i,
  input  logic                    wr_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [LINE_BYTES*8-1:0] wr_line_data_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [LINE_BYTES*8-1:0] rdata_o,
  output logic                    write_done_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int unsigned c_OFF     = $clog2(LINE_BYTES);
  localparam int unsigned c_LW      = ADDR_WIDTH - c_OFF;
  localparam int unsigned c_NLINES  = MEM_SIZE / LINE_BYTES;
  localparam int unsigned c_IDX_W   = (c_NLINES > 1) ? $clog2(c_NLINES) : 1;
  localparam int unsigned c_MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

  localparam logic [c_CNT_W-1:0] c_RD_INIT     = c_CNT_W'(RD_LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_WR_INIT     = c_CNT_W'(WR_LATENCY - 1);
  localparam logic [c_LW:0]      c_NLINES_EXT  = (c_LW + 1)'(c_NLINES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_CNT_W-1:0]        r_cnt;
  logic [c_LW-1:0]           r_line;
  logic [LINE_BYTES*8-1:0]   r_wdata;
  logic [LINE_BYTES*8-1:0]   r_mem [c_NLINES];

  logic                      w_rd_fire;
  logic                      w_wr_fire;
  logic                      w_oor;
  logic [c_IDX_W-1:0]        w_idx;
  logic                      w_unused_off;

  assign w_unused_off = ^req_addr_i[c_OFF-1:0];
  assign w_idx        = r_line[c_IDX_W-1:0];
  assign w_oor        = {1'b0, r_line} >= c_NLINES_EXT;
  assign busy_o       = (r_state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant is suppressed while reset is asserted, since reset would discard it.
  always_comb begin
    w_state_nxt = r_state;
    gnt_o       = 1'b0;
    w_rd_fire   = 1'b0;
    w_wr_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((rd_req_valid_i || wr_req_valid_i) && !rst_i) begin
          gnt_o       = 1'b1;
          w_state_nxt = wr_req_valid_i ? S_WR_WAIT : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_rd_fire   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (r_cnt == '0) begin
          w_wr_fire   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt        <= '0;
      r_line       <= '0;
      r_wdata      <= '0;
      rvalid_o     <= 1'b0;
      write_done_o <= 1'b0;
      err_o        <= 1'b0;
      rdata_o      <= '0;
    end else begin
      rvalid_o     <= w_rd_fire;
      write_done_o <= w_wr_fire;
      err_o        <= (w_rd_fire || w_wr_fire) && w_oor;
      if (gnt_o) begin
        r_line  <= req_addr_i[ADDR_WIDTH-1:c_OFF];
        r_wdata <= wr_line_data_i;
        r_cnt   <= wr_req_valid_i ? c_WR_INIT : c_RD_INIT;
      end else if (busy_o && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end
      if (w_rd_fire) begin
        rdata_o <= w_oor ? '0 : r_mem[w_idx];
      end
    end
  end

  // Backing store is never cleared; a reset on the commit edge drops the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_fire && !w_oor) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_mem_responder
//  Purpose  : Self-checking bench for line_mem_responder with a cycle-level
//             transaction model, a vector table and directed corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_mem_responder;

  localparam int MEM_SIZE = 4096;
  localparam int AW       = 20;
  localparam int LB       = 16;
  localparam int RDL      = 5;
  localparam int WRL      = 5;
  localparam int NL       = MEM_SIZE / LB;
  localparam int DW       = LB * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd  = 1'b0;
  logic          wr  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic          gnt, rvalid, wdone, err, busy;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  line_mem_responder #(
    .MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW), .LINE_BYTES(LB),
    .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rd_req_valid_i(rd), .wr_req_valid_i(wr),
    .req_addr_i(addr), .wr_line_data_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .write_done_o(wdone), .err_o(err), .busy_o(busy)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: a memory array plus one pending request with a due cycle.
  logic [DW-1:0] m_mem [NL];
  bit            m_pend = 0;
  bit            m_wr   = 0;
  int            m_line = 0;
  logic [DW-1:0] m_data = '0;
  int            m_due  = 0;
  int            cyc    = 0;
  bit            e_rvalid = 0, e_wdone = 0, e_err = 0;
  logic [DW-1:0] e_rdata = '0;

  logic          s_gnt, s_rvalid, s_wdone, s_err;
  logic [DW-1:0] s_rdata;

  localparam logic [DW-1:0] L0   = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [DW-1:0] L4   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] L255 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [DW-1:0] DBEF = {4{32'hDEADBEEF}};
  localparam logic [DW-1:0] COFE = {4{32'hC0FFEE00}};
  localparam logic [DW-1:0] CAFE = {4{32'hCAFEBABE}};
  localparam logic [DW-1:0] BOTH = {4{32'h600DF00D}};

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit rq, input bit wq, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit do_chk);
    bit eg;
    bit oor;
    rst = r; rd = rq; wr = wq; addr = a; wdata = d;
    #2;
    s_gnt = gnt; s_rvalid = rvalid; s_wdone = wdone; s_err = err; s_rdata = rdata;
    eg = !m_pend && (rq || wq) && !r;
    if (do_chk) begin
      chk("gnt", DW'(gnt), DW'(eg));
      chk("busy", DW'(busy), DW'(m_pend));
      chk("rvalid", DW'(rvalid), DW'(e_rvalid));
      chk("write_done", DW'(wdone), DW'(e_wdone));
      chk("err", DW'(err), DW'(e_err));
      chk("rdata", rdata, e_rdata);
    end
    e_rvalid = 0; e_wdone = 0; e_err = 0;
    if (r) begin
      m_pend  = 0;
      e_rdata = '0;
    end else if (m_pend && cyc == m_due) begin
      oor = (m_line >= NL);
      if (m_wr) begin
        if (!oor) m_mem[m_line] = m_data;
        e_wdone = 1;
      end else begin
        e_rvalid = 1;
        e_rdata  = oor ? '0 : m_mem[m_line];
      end
      e_err  = oor;
      m_pend = 0;
    end else if (eg) begin
      m_pend = 1;
      m_wr   = wq;
      m_line = int'(a) / LB;
      m_data = d;
      m_due  = cyc + (wq ? WRL : RDL);
    end
    cyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd_o, output bit er, output int lat, output bit kind_wr);
    bit g   = 0;
    bit got = 0;
    lat = 0; rd_o = '0; er = 0; kind_wr = 0;
    for (int k = 0; k < 20 && !g; k++) begin
      cycle(1'b0, !w, w, a, d, 1'b1);
      g = s_gnt;
    end
    chk("txn_grant", DW'(g), DW'(1));
    for (int k = 0; k < 40 && !got; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      lat++;
      if (s_rvalid || s_wdone) begin
        got = 1; rd_o = s_rdata; er = s_err; kind_wr = s_wdone;
      end
    end
    chk("txn_response", DW'(got), DW'(1));
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DW-1:0] rdv;
    bit            er, kw;
    int            lat, cnt;
    logic [DW-1:0] saved;

    for (int i = 0; i < NL; i++) m_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    m_mem[0] = L0; m_mem[4] = L4; m_mem[255] = L255;
    for (int i = 0; i < NL; i++) dut.r_mem[i] = m_mem[i];

    vecs[0] = '{0, 20'h0004C, '0,                 L4,   0};
    vecs[1] = '{1, 20'h00100, DBEF,               '0,   0};
    vecs[2] = '{0, 20'h00108, '0,                 DBEF, 0};
    vecs[3] = '{0, 20'h01000, '0,                 '0,   1};
    vecs[4] = '{1, 20'h01FF0, {4{32'h11111111}},  '0,   1};
    vecs[5] = '{0, 20'h00000, '0,                 L0,   0};
    vecs[6] = '{0, 20'h00FFC, '0,                 L255, 0};
    vecs[7] = '{1, 20'h00FF0, COFE,               '0,   0};
    vecs[8] = '{0, 20'h00FF4, '0,                 COFE, 0};
    vecs[9] = '{0, 20'hFFFFF, '0,                 '0,   1};

    @(posedge clk);
    #2;
    // Reset with a read request held; only the second reset cycle is defined.
    cycle(1'b1, 1'b1, 1'b0, 20'h0004C, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 20'h0004C, '0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 20'h0004C, '0, 1'b1);
    chk("grant_after_reset", DW'(s_gnt), DW'(1));
    idle(RDL + 1);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].is_wr, vecs[i].a, vecs[i].d, rdv, er, lat, kw);
      chk($sformatf("vec%0d_kind", i), DW'(kw), DW'(vecs[i].is_wr));
      chk($sformatf("vec%0d_err", i), DW'(er), DW'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), DW'(lat), DW'(vecs[i].is_wr ? WRL + 1 : RDL + 1));
      if (!vecs[i].is_wr) chk($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rdata);
    end

    // Read granted in the write-done cycle sees the new line.
    cycle(1'b0, 1'b0, 1'b1, 20'h00200, CAFE, 1'b1);
    idle(WRL);
    cycle(1'b0, 1'b1, 1'b0, 20'h00208, '0, 1'b1);
    chk("b2b_wdone", DW'(s_wdone), DW'(1));
    chk("b2b_gnt", DW'(s_gnt), DW'(1));
    idle(RDL);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("b2b_rvalid", DW'(s_rvalid), DW'(1));
    chk("b2b_rdata", s_rdata, CAFE);

    // Requests toggling while busy are ignored; both requests in idle favour the write.
    cycle(1'b0, 1'b1, 1'b0, 20'h00040, '0, 1'b1);
    for (int k = 0; k < RDL; k++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'h00300, '0, 1'b1);
      chk("hold_gnt", DW'(s_gnt), DW'(0));
    end
    cycle(1'b0, 1'b1, 1'b1, 20'h00300, BOTH, 1'b1);
    chk("both_rvalid", DW'(s_rvalid), DW'(1));
    chk("both_gnt", DW'(s_gnt), DW'(1));
    idle(WRL);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("both_wdone", DW'(s_wdone), DW'(1));
    txn(1'b0, 20'h00300, '0, rdv, er, lat, kw);
    chk("both_readback", rdv, BOTH);

    // Reset mid-read: no response may follow.
    cycle(1'b0, 1'b1, 1'b0, 20'h00040, '0, 1'b1);
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      if (s_rvalid) cnt++;
    end
    chk("rst_read_no_rvalid", DW'(cnt), DW'(0));

    // Reset mid-write: line stays as it was.
    saved = m_mem[5];
    cycle(1'b0, 1'b0, 1'b1, 20'h00050, {4{32'hBAD0BAD0}}, 1'b1);
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      if (s_wdone) cnt++;
    end
    chk("rst_write_no_wdone", DW'(cnt), DW'(0));
    txn(1'b0, 20'h00050, '0, rdv, er, lat, kw);
    chk("rst_write_unchanged", rdv, saved);

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(0, 3) == 3) ? AW'($urandom_range(32'h1000, 32'hFFFFF))
                                       : AW'($urandom_range(0, 32'hFFF));
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ra,
            {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
